regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Architectural integer register file for the rvga pipeline; receiver end of the writeback write port (writeback_rd / writeback_rd_data / writeback_rd_w_v).
- Serves two registered read ports to decode.
- Tracks in-flight destination registers with per-register pending counters so decode can stall on RAW hazards.
- Writeback commits write data and decrements pending counters; decode issue increments them.

Parameters:
XLEN, 32, data width of every register and read/write data port
PEND_W, 2, width of each per-register pending counter (max 2^PEND_W-1 in-flight writers per rd)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_ni  in  1  reset, asynchronous, active-low
decode_rs1  in  5  read address port 1
decode_rs2  in  5  read address port 2
decode_rs1_data  out  XLEN  port 1 read data, registered, valid the cycle after address
decode_rs2_data  out  XLEN  port 2 read data, registered
decode_rs1_busy  out  1  combinational: rs1 has an outstanding writer
decode_rs2_busy  out  1  combinational: rs2 has an outstanding writer
decode_issue_v  in  1  instruction issued this cycle
decode_issue_rd  in  5  destination of issued instruction
decode_issue_rd_w_v  in  1  issued instruction writes rd
issue_stall_o  out  1  combinational: pending counter of decode_issue_rd saturated; issue must be held
flush_i  in  1  pipeline flush; clears all pending counters
writeback_rd  in  5  write address from writeback
writeback_rd_data  in  XLEN  write data from writeback
writeback_rd_w_v  in  1  write enable from writeback

Behaviour:
- Reset (rst_ni low, asynchronous): all 32 registers = 0; all pending counters = 0; decode_rs1_data = decode_rs2_data = 0. Busy/stall outputs then evaluate to 0.
- x0:
  - Reads always return 0.
  - Writes to x0 are ignored (register and counter).
  - x0 is never busy and never counted.
  - issue_stall_o = 0 when decode_issue_rd = 0.
- Write: on the edge where writeback_rd_w_v = 1 and writeback_rd != 0, reg[writeback_rd] <= writeback_rd_data. This happens even when the counter is 0 or flush_i = 1.
- Read:
  - decode_rsN_data <= (writeback_rd_w_v and writeback_rd == decode_rsN and decode_rsN != 0) ? writeback_rd_data : reg[decode_rsN].
  - Latency 1 cycle.
  - Same-cycle write is bypassed; read-during-write never returns stale data.
- Issue increment (inc): decode_issue_v and decode_issue_rd_w_v and decode_issue_rd != 0 and !issue_stall_o.
- Writeback decrement (dec): writeback_rd_w_v and writeback_rd != 0 and cnt[writeback_rd] != 0.
- Counter update, per register r:
  - flush_i = 1: cnt[r] <= 0 for all r; inc ignored.
  - inc and dec both target r: cnt unchanged.
  - Only inc: cnt+1.
  - Only dec: cnt-1.
  - Writeback to a register with cnt = 0: no underflow, cnt stays 0, data still written.
- Saturation: issue_stall_o = decode_issue_v and decode_issue_rd_w_v and decode_issue_rd != 0 and cnt[decode_issue_rd] == 2^PEND_W-1 and not dec of the same rd this cycle. While stalled, the counter does not change.
- Busy:
  - decode_rsN_busy = (decode_rsN != 0) and cnt[decode_rsN] != 0, with one exception.
  - Exception: busy = 0 when cnt == 1 and a dec targets that register this cycle. The bypass already supplies the data.
  - Busy ignores a same-cycle issue; the issuing instruction's own rd is not its source hazard.
  - Busy ignores flush_i; it is valid the cycle after flush.
- No state machine beyond the counters. All outputs are glitch-free functions of registered state and current inputs.

Test Plan:
- Reset then read x1/x2 -> data 0, busy 0; assert rst_ni low mid-run with reg x5 = 0xDEADBEEF -> next read of x5 returns 0 immediately after release.
- Write x3 = 0x12345678 (no issue), read rs1 = x3 next cycle -> 0x12345678; same-cycle write x4 = 0xCAFEF00D with rs2 = x4 -> data 0xCAFEF00D the following cycle (bypass).
- Write x0 = 0xFFFFFFFF, issue rd = x0 -> read x0 = 0, busy 0, stall 0, counter untouched.
- Issue rd = x7 twice (cnt 2), rs1 = x7 -> busy 1; writeback x7 once -> busy 1; second writeback x7 -> busy 0 in that cycle, data = writeback value next cycle.
- Issue rd = x9 three times (PEND_W = 2, cnt 3), 4th issue -> issue_stall_o = 1, cnt stays 3; 4th issue with simultaneous writeback x9 -> stall 0, cnt stays 3.
- cnt[x10] = 2, pulse flush_i with simultaneous issue rd = x10 and writeback x10 = 0x55 -> all counters 0, busy 0 next cycle, x10 = 0x55.

Source files
------------

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Architectural integer register file (x0..x31) with two
//               registered read ports and per-register pending counters.
//               Decode issue increments a destination's counter, writeback
//               decrements it, and decode uses the counters to detect RAW
//               hazards and to stall an issue when a counter is full.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int PEND_W = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      decode_rs1,
    input  logic [4:0]      decode_rs2,
    output logic [XLEN-1:0] decode_rs1_data,
    output logic [XLEN-1:0] decode_rs2_data,
    output logic            decode_rs1_busy,
    output logic            decode_rs2_busy,
    input  logic            decode_issue_v,
    input  logic [4:0]      decode_issue_rd,
    input  logic            decode_issue_rd_w_v,
    output logic            issue_stall_o,
    input  logic            flush_i,
    input  logic [4:0]      writeback_rd,
    input  logic [XLEN-1:0] writeback_rd_data,
    input  logic            writeback_rd_w_v
);

    localparam logic [PEND_W-1:0] c_cnt_max  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] c_cnt_one  = PEND_W'(1);
    localparam logic [PEND_W-1:0] c_cnt_zero = '0;

    logic [XLEN-1:0]   r_regs [32];
    logic [PEND_W-1:0] r_cnt  [32];

    logic w_wb_en;        // writeback targets a real register
    logic w_dec;          // writeback retires one pending writer
    logic w_issue_req;    // decode wants to allocate a pending writer
    logic w_inc;          // allocation actually happens this cycle
    logic w_dec_issue_rd; // the decrement hits the issuing destination
    logic w_rs1_wb;
    logic w_rs2_wb;

    // Write-enable and counter-step qualifiers shared by the state and outputs
    assign w_wb_en        = writeback_rd_w_v && (writeback_rd != 5'd0);
    assign w_dec          = w_wb_en && (r_cnt[writeback_rd] != c_cnt_zero);
    assign w_issue_req    = decode_issue_v && decode_issue_rd_w_v && (decode_issue_rd != 5'd0);
    assign w_dec_issue_rd = w_dec && (writeback_rd == decode_issue_rd);

    // A full counter blocks the issue unless a writer to the same rd retires now
    assign issue_stall_o  = w_issue_req && (r_cnt[decode_issue_rd] == c_cnt_max) && !w_dec_issue_rd;
    assign w_inc          = w_issue_req && !issue_stall_o;

    // The last outstanding writer retiring this cycle is covered by the read bypass
    assign w_rs1_wb        = w_wb_en && (writeback_rd == decode_rs1);
    assign w_rs2_wb        = w_wb_en && (writeback_rd == decode_rs2);
    assign decode_rs1_busy = (decode_rs1 != 5'd0) && (r_cnt[decode_rs1] != c_cnt_zero)
                             && !((r_cnt[decode_rs1] == c_cnt_one) && w_rs1_wb);
    assign decode_rs2_busy = (decode_rs2 != 5'd0) && (r_cnt[decode_rs2] != c_cnt_zero)
                             && !((r_cnt[decode_rs2] == c_cnt_one) && w_rs2_wb);

    // Register array write and pending-counter update (flush wins over issue)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            if (w_wb_en) begin
                r_regs[writeback_rd] <= writeback_rd_data;
            end
            if (flush_i) begin
                for (int i = 0; i < 32; i++) begin
                    r_cnt[i] <= '0;
                end
            end else begin
                // Increment and decrement of the same register cancel out
                if (w_inc && !w_dec_issue_rd) begin
                    r_cnt[decode_issue_rd] <= r_cnt[decode_issue_rd] + c_cnt_one;
                end
                if (w_dec && !(w_inc && (writeback_rd == decode_issue_rd))) begin
                    r_cnt[writeback_rd] <= r_cnt[writeback_rd] - c_cnt_one;
                end
            end
        end
    end

    // Registered read ports with same-cycle writeback bypass
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            decode_rs1_data <= '0;
            decode_rs2_data <= '0;
        end else begin
            decode_rs1_data <= w_rs1_wb ? writeback_rd_data : r_regs[decode_rs1];
            decode_rs2_data <= w_rs2_wb ? writeback_rd_data : r_regs[decode_rs2];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Directed and random stimulus for regfile_scoreboard, checked
//               against an array-based model of registers and pending counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int XLEN   = 32;
    localparam int PEND_W = 2;
    localparam int CMAX   = (1 << PEND_W) - 1;

    logic            clk;
    logic            rst_n;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_busy, rs2_busy;
    logic            iss_v, iss_w;
    logic [4:0]      iss_rd;
    logic            stall;
    logic            flush;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_v;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state: plain integers, one entry per architectural register
    logic [XLEN-1:0] m_reg [32];
    int              m_cnt [32];

    regfile_scoreboard #(.XLEN(XLEN), .PEND_W(PEND_W)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .decode_rs1         (rs1),
        .decode_rs2         (rs2),
        .decode_rs1_data    (rs1_data),
        .decode_rs2_data    (rs2_data),
        .decode_rs1_busy    (rs1_busy),
        .decode_rs2_busy    (rs2_busy),
        .decode_issue_v     (iss_v),
        .decode_issue_rd    (iss_rd),
        .decode_issue_rd_w_v(iss_w),
        .issue_stall_o      (stall),
        .flush_i            (flush),
        .writeback_rd       (wb_rd),
        .writeback_rd_data  (wb_data),
        .writeback_rd_w_v   (wb_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
    endtask

    // One clock: drive inputs after the falling edge, check the combinational
    // outputs before the rising edge, then check read data after it.
    task automatic cycle(input logic [4:0] a1, input logic [4:0] a2,
                         input logic iv, input logic [4:0] ird, input logic fl,
                         input logic wv, input logic [4:0] wrd, input logic [XLEN-1:0] wd);
        logic e_b1, e_b2, e_st, inc, dec;
        @(negedge clk);
        rs1 = a1; rs2 = a2; iss_v = iv; iss_w = iv; iss_rd = ird;
        flush = fl; wb_v = wv; wb_rd = wrd; wb_data = wd;
        #1;
        dec  = wv && (wrd != 0) && (m_cnt[wrd] != 0);
        e_b1 = (a1 != 0) && (m_cnt[a1] != 0) && !(m_cnt[a1] == 1 && dec && wrd == a1);
        e_b2 = (a2 != 0) && (m_cnt[a2] != 0) && !(m_cnt[a2] == 1 && dec && wrd == a2);
        e_st = iv && (ird != 0) && (m_cnt[ird] == CMAX) && !(dec && wrd == ird);
        inc  = iv && (ird != 0) && !e_st;
        chk("rs1_busy", XLEN'(rs1_busy), XLEN'(e_b1));
        chk("rs2_busy", XLEN'(rs2_busy), XLEN'(e_b2));
        chk("stall", XLEN'(stall), XLEN'(e_st));
        if (wv && wrd != 0) m_reg[wrd] = wd;
        if (fl) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else begin
            if (inc) m_cnt[ird] = m_cnt[ird] + 1;
            if (dec) m_cnt[wrd] = m_cnt[wrd] - 1;
        end
        @(posedge clk);
        #1;
        chk("rs1_data", rs1_data, m_reg[a1]);
        chk("rs2_data", rs2_data, m_reg[a2]);
    endtask

    initial begin
        rst_n = 1'b0; rs1 = '0; rs2 = '0; iss_v = 1'b0; iss_w = 1'b0; iss_rd = '0;
        flush = 1'b0; wb_v = 1'b0; wb_rd = '0; wb_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        cycle(5'd1, 5'd2, 0, 5'd0, 0, 0, 5'd0, '0);
        chk("reset_x1", rs1_data, 32'h0);

        // Asynchronous reset mid-run clears a written register
        cycle(5'd0, 5'd0, 0, 5'd0, 0, 1, 5'd5, 32'hDEADBEEF);
        cycle(5'd5, 5'd0, 0, 5'd0, 0, 0, 5'd0, '0);
        chk("x5_before_rst", rs1_data, 32'hDEADBEEF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", rs1_data, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(5'd5, 5'd0, 0, 5'd0, 0, 0, 5'd0, '0);
        chk("x5_after_rst", rs1_data, 32'h0);

        // Plain write then read, and same-cycle bypass
        cycle(5'd0, 5'd0, 0, 5'd0, 0, 1, 5'd3, 32'h12345678);
        cycle(5'd3, 5'd0, 0, 5'd0, 0, 0, 5'd0, '0);
        chk("x3_read", rs1_data, 32'h12345678);
        cycle(5'd0, 5'd4, 0, 5'd0, 0, 1, 5'd4, 32'hCAFEF00D);
        chk("x4_bypass", rs2_data, 32'hCAFEF00D);

        // x0 write and issue are ignored
        cycle(5'd0, 5'd0, 1, 5'd0, 0, 1, 5'd0, 32'hFFFFFFFF);
        cycle(5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, '0);
        chk("x0_read", rs1_data, 32'h0);

        // Two writers to x7 retire one by one
        cycle(5'd0, 5'd0, 1, 5'd7, 0, 0, 5'd0, '0);
        cycle(5'd0, 5'd0, 1, 5'd7, 0, 0, 5'd0, '0);
        cycle(5'd7, 5'd0, 0, 5'd0, 0, 0, 5'd0, '0);
        chk("x7_busy_cnt2", XLEN'(rs1_busy), 32'h1);
        cycle(5'd7, 5'd0, 0, 5'd0, 0, 1, 5'd7, 32'h00000A0A);
        cycle(5'd7, 5'd0, 0, 5'd0, 0, 1, 5'd7, 32'h00000B0B);
        chk("x7_last_wb_data", rs1_data, 32'h00000B0B);

        // Saturate x9, then a retire allows the issue with the count unchanged
        repeat (3) cycle(5'd0, 5'd0, 1, 5'd9, 0, 0, 5'd0, '0);
        cycle(5'd9, 5'd0, 1, 5'd9, 0, 0, 5'd0, '0);
        cycle(5'd9, 5'd0, 1, 5'd9, 0, 1, 5'd9, 32'h99);
        cycle(5'd9, 5'd0, 1, 5'd9, 0, 0, 5'd0, '0);
        chk("x9_still_full", XLEN'(stall), 32'h1);

        // Flush with a simultaneous issue and writeback to x10
        cycle(5'd0, 5'd0, 1, 5'd10, 0, 0, 5'd0, '0);
        cycle(5'd0, 5'd0, 1, 5'd10, 0, 0, 5'd0, '0);
        cycle(5'd10, 5'd9, 1, 5'd10, 1, 1, 5'd10, 32'h55);
        cycle(5'd10, 5'd9, 0, 5'd0, 0, 0, 5'd0, '0);
        chk("x10_flush_busy", XLEN'(rs1_busy), 32'h0);
        chk("x10_flush_data", rs1_data, 32'h55);

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            cycle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 40) == 0),
                  ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 7)),
                  XLEN'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
